// File: rtl/cache_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cache_controller
//   Memory-stage sequencer between the pipeline, a 2-way set-associative data
//   cache and a 64-bit block SRAM controller. Read hits complete in the cycle
//   they are presented. Read misses fetch a 64-bit block and refill the cache.
//   Stores are written through to SRAM (no write allocate). On a store hit the
//   cached block is rewritten, merged with the sibling word captured in IDLE.
//
// Ports
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   MEM_R_EN/MEM_W_EN  : load/store request, held until ready (store wins)
//   address, wdata     : byte address (word aligned) and store data
//   rdata, ready       : load data and request-complete strobe (stall release)
//   cache_*            : cache address, LRU touch, write strobe, update/allocate
//                        select and the two block words; hit/rdata are comb
//   sram_*             : block read / word write handshake to SRAM controller
// -----------------------------------------------------------------------------
module cache_controller #(
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  // pipeline side
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  // cache side
  output logic [17:0] cache_address,
  output logic        cache_en_read,
  output logic        cache_en_write,
  output logic        cache_update,
  output logic [31:0] cache_wdata1,
  output logic [31:0] cache_wdata2,
  input  logic        cache_hit,
  input  logic [31:0] cache_rdata,
  // SRAM controller side
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned CADDR_W = 18;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_READ_MISS  = 2'd1,
    S_WRITE_SRAM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sib_hit;
  logic [WORD_W-1:0]   r_sib_word;
  logic                w_sib_capture;
  logic [CADDR_W-1:0]  w_off;

  // Only the low 18 bits of the rebased address reach the cache; modulo
  // arithmetic makes the truncated difference equal the low bits of the full one.
  assign w_off = CADDR_W'(address - 32'(BASE_ADDR));

  // State register and sibling-word capture for the store merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sib_hit  <= 1'b0;
      r_sib_word <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_sib_capture) begin
        r_sib_hit  <= cache_hit;
        r_sib_word <= cache_rdata;
      end
    end
  end

  // Next state and outputs; everything is held at zero while reset is high.
  always_comb begin
    w_next_state   = r_state;
    w_sib_capture  = 1'b0;
    rdata          = '0;
    ready          = 1'b0;
    cache_address  = '0;
    cache_en_read  = 1'b0;
    cache_en_write = 1'b0;
    cache_update   = 1'b0;
    cache_wdata1   = '0;
    cache_wdata2   = '0;
    sram_r_en      = 1'b0;
    sram_w_en      = 1'b0;
    sram_address   = '0;
    sram_wdata     = '0;

    if (rst) begin
      w_next_state = S_IDLE;
    end else begin
      cache_address = w_off;
      sram_address  = address;
      sram_wdata    = wdata;

      case (r_state)
        S_IDLE: begin
          if (MEM_W_EN) begin
            // Look up the other word of the block so a store hit can rewrite
            // the whole line without a second cache access.
            cache_address[2] = ~w_off[2];
            w_sib_capture    = 1'b1;
            w_next_state     = S_WRITE_SRAM;
          end else if (MEM_R_EN) begin
            if (cache_hit) begin
              rdata         = cache_rdata;
              ready         = 1'b1;
              cache_en_read = 1'b1;
            end else begin
              w_next_state = S_READ_MISS;
            end
          end
        end

        S_READ_MISS: begin
          sram_r_en = 1'b1;
          if (sram_ready) begin
            cache_en_write = 1'b1;
            cache_update   = 1'b0;
            cache_wdata1   = sram_rdata[31:0];
            cache_wdata2   = sram_rdata[63:32];
            rdata          = w_off[2] ? sram_rdata[63:32] : sram_rdata[31:0];
            ready          = 1'b1;
            w_next_state   = S_IDLE;
          end
        end

        S_WRITE_SRAM: begin
          sram_w_en = 1'b1;
          if (sram_ready) begin
            ready        = 1'b1;
            w_next_state = S_IDLE;
            if (r_sib_hit) begin
              cache_en_write = 1'b1;
              cache_update   = 1'b1;
              if (w_off[2]) begin
                cache_wdata1 = r_sib_word;
                cache_wdata2 = wdata;
              end else begin
                cache_wdata1 = wdata;
                cache_wdata2 = r_sib_word;
              end
            end
          end
        end

        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
// Bench for cache_controller: behavioural 2-way cache and latency-programmable
// SRAM around the DUT; expected load data and completion latency go into a
// queue when a request is issued and are popped when ready is seen.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] cache_address;
  logic        cache_en_read, cache_en_write, cache_update;
  logic [31:0] cache_wdata1, cache_wdata2;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  cache_controller #(.BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_en_read(cache_en_read),
    .cache_en_write(cache_en_write), .cache_update(cache_update),
    .cache_wdata1(cache_wdata1), .cache_wdata2(cache_wdata2),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- cache model: 64 sets x 2 ways x 2 words, 1-bit LRU
  bit          c_valid [64][2];
  bit   [8:0]  c_tag   [64][2];
  bit   [31:0] c_data  [64][2][2];
  bit          c_lru   [64];
  logic        hit_way;
  int          cache_wr_count = 0;

  always_comb begin
    cache_hit   = 1'b0;
    cache_rdata = '0;
    hit_way     = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (c_valid[cache_address[8:3]][w] && c_tag[cache_address[8:3]][w] == cache_address[17:9]) begin
        cache_hit   = 1'b1;
        hit_way     = w[0];
        cache_rdata = c_data[cache_address[8:3]][w][cache_address[2]];
      end
    end
  end

  always @(posedge clk) begin
    if (cache_en_write) begin
      cache_wr_count <= cache_wr_count + 1;
      if (cache_update) begin
        if (cache_hit) begin
          c_data[cache_address[8:3]][hit_way][0] <= cache_wdata1;
          c_data[cache_address[8:3]][hit_way][1] <= cache_wdata2;
          c_lru[cache_address[8:3]] <= ~hit_way;
        end
      end else begin
        c_valid[cache_address[8:3]][c_lru[cache_address[8:3]]]   <= 1'b1;
        c_tag  [cache_address[8:3]][c_lru[cache_address[8:3]]]   <= cache_address[17:9];
        c_data [cache_address[8:3]][c_lru[cache_address[8:3]]][0] <= cache_wdata1;
        c_data [cache_address[8:3]][c_lru[cache_address[8:3]]][1] <= cache_wdata2;
        c_lru  [cache_address[8:3]] <= ~c_lru[cache_address[8:3]];
      end
    end else if (cache_en_read && cache_hit) begin
      c_lru[cache_address[8:3]] <= ~hit_way;
    end
  end

  // ---------------- SRAM model: ready in the Nth cycle the enable is seen
  bit   [31:0] sram_mem [1024];
  bit          mem_loaded = 1'b0;
  int          sram_lat   = 1;
  int          sram_cnt   = 0;
  bit          spur       = 1'b0;
  logic [9:0]  blk0, blk1;

  assign sram_ready = (((sram_r_en || sram_w_en) && (sram_cnt == sram_lat - 1)) || spur);

  always_comb begin
    blk0       = {sram_address[11:3], 1'b0};
    blk1       = {sram_address[11:3], 1'b1};
    sram_rdata = {sram_mem[blk1], sram_mem[blk0]};
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      mem_loaded    <= 1'b1;
      sram_mem[256] <= 32'hAAAA0001;
      sram_mem[257] <= 32'hBBBB0002;
      sram_mem[260] <= 32'h0BADCAFE;
      sram_mem[261] <= 32'h0000F00D;
      sram_mem[262] <= 32'h600DF00D;
    end else if (sram_w_en && sram_ready) begin
      sram_mem[sram_address[11:2]] <= sram_wdata;
    end
    if ((sram_r_en || sram_w_en) && !sram_ready) sram_cnt <= sram_cnt + 1;
    else                                         sram_cnt <= 0;
  end

  // ---------------- reference memory and scoreboard
  logic [31:0] ref_mem [1024];
  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    int          cycles;
  } exp_t;
  exp_t exp_q[$];

  // per-request monitor results, filled by run_req
  bit          m_both;
  int          m_rcyc, m_wcyc, m_cwr;
  logic        m_rdy_ewr, m_rdy_upd, m_rdy_enrd;
  logic [31:0] m_rdy_wd1, m_rdy_wd2;

  task automatic push_exp(input logic [31:0] d, input bit chk, input int cyc);
    exp_t e;
    e.data = d; e.chk_data = chk; e.cycles = cyc;
    exp_q.push_back(e);
  endtask

  // Present one request from just after a clock edge and wait (bounded) for ready.
  task automatic run_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] o_rdata, output int o_cyc);
    MEM_R_EN = r; MEM_W_EN = w; address = a; wdata = d;
    o_rdata = 'x; o_cyc = 0;
    m_both = 0; m_rcyc = 0; m_wcyc = 0; m_cwr = 0;
    m_rdy_ewr = 'x; m_rdy_upd = 'x; m_rdy_enrd = 'x; m_rdy_wd1 = 'x; m_rdy_wd2 = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      o_cyc++;
      if (sram_r_en && sram_w_en) m_both = 1;
      if (sram_r_en)      m_rcyc++;
      if (sram_w_en)      m_wcyc++;
      if (cache_en_write) m_cwr++;
      if (ready) begin
        o_rdata    = rdata;
        m_rdy_ewr  = cache_en_write;
        m_rdy_upd  = cache_update;
        m_rdy_enrd = cache_en_read;
        m_rdy_wd1  = cache_wdata1;
        m_rdy_wd2  = cache_wdata2;
        break;
      end
    end
    @(posedge clk); #1;
    MEM_R_EN = 0; MEM_W_EN = 0;
    if (w) ref_mem[a[11:2]] = d;
  endtask

  task automatic test_reset();
    rst = 1; MEM_R_EN = 1; MEM_W_EN = 0; address = 32'd1028; wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++;
    if ({sram_r_en, sram_w_en, cache_en_read, cache_en_write, cache_update} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0",
                         {sram_r_en, sram_w_en, cache_en_read, cache_en_write, cache_update});
    end
    n_checks++;
    if ({cache_address, sram_address, sram_wdata, cache_wdata1, cache_wdata2} !== '0) begin
      n_fail++; $display("FAIL reset_buses: caddr %h saddr %h swd %h wd1 %h wd2 %h want all 0",
                         cache_address, sram_address, sram_wdata, cache_wdata1, cache_wdata2);
    end
    @(posedge clk); #1;
    rst = 0; MEM_R_EN = 0;
  endtask

  task automatic test_read_miss();
    logic [31:0] rd; int cyc; exp_t e;
    sram_lat = 5;
    push_exp(ref_mem[256], 1, 6);
    run_req(1, 0, 32'd1024, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data) begin n_fail++; $display("FAIL miss_rdata: got %h want %h", rd, e.data); end
    n_checks++;
    if (cyc !== e.cycles) begin n_fail++; $display("FAIL miss_latency: got %0d want %0d", cyc, e.cycles); end
    n_checks++;
    if (m_rcyc !== 5) begin n_fail++; $display("FAIL miss_r_en_held: got %0d cycles want 5", m_rcyc); end
    n_checks++;
    if ({m_rdy_ewr, m_rdy_upd} !== 2'b10) begin
      n_fail++; $display("FAIL miss_fill_strobes: got en_write=%b update=%b want 1,0", m_rdy_ewr, m_rdy_upd);
    end
    n_checks++;
    if ({m_rdy_wd2, m_rdy_wd1} !== 64'hBBBB0002_AAAA0001) begin
      n_fail++; $display("FAIL miss_fill_data: got %h_%h want bbbb0002_aaaa0001", m_rdy_wd2, m_rdy_wd1);
    end
    n_checks++;
    if (m_cwr !== 1) begin n_fail++; $display("FAIL miss_single_fill: got %0d writes want 1", m_cwr); end
  endtask

  task automatic test_read_hit();
    logic [31:0] rd; int cyc; exp_t e;
    push_exp(32'hBBBB0002, 1, 1);
    run_req(1, 0, 32'd1028, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", rd, e.data); end
    n_checks++;
    if (cyc !== e.cycles) begin n_fail++; $display("FAIL hit_latency: got %0d want %0d", cyc, e.cycles); end
    n_checks++;
    if (m_rdy_enrd !== 1'b1) begin n_fail++; $display("FAIL hit_en_read: got %b want 1", m_rdy_enrd); end
    n_checks++;
    if ((m_cwr + m_rcyc) !== 0) begin
      n_fail++; $display("FAIL hit_no_side_effects: got %0d writes %0d sram reads want 0", m_cwr, m_rcyc);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int cyc; exp_t e;
    sram_lat = 3;
    push_exp(32'h0, 0, 4);
    run_req(0, 1, 32'd1028, 32'h12345678, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== e.cycles) begin n_fail++; $display("FAIL wr_hit_latency: got %0d want %0d", cyc, e.cycles); end
    n_checks++;
    if (m_wcyc !== 3 || m_rcyc !== 0) begin
      n_fail++; $display("FAIL wr_hit_sram_strobes: got w_en %0d r_en %0d cycles want 3,0", m_wcyc, m_rcyc);
    end
    n_checks++;
    if ({m_rdy_ewr, m_rdy_upd} !== 2'b11) begin
      n_fail++; $display("FAIL wr_hit_update: got en_write=%b update=%b want 1,1", m_rdy_ewr, m_rdy_upd);
    end
    n_checks++;
    if ({m_rdy_wd2, m_rdy_wd1} !== 64'h12345678_AAAA0001) begin
      n_fail++; $display("FAIL wr_hit_merge: got %h_%h want 12345678_aaaa0001", m_rdy_wd2, m_rdy_wd1);
    end
    n_checks++;
    if (sram_mem[257] !== 32'h12345678) begin
      n_fail++; $display("FAIL wr_hit_sram_data: got %h want 12345678", sram_mem[257]);
    end
    push_exp(ref_mem[257], 1, 1);
    run_req(1, 0, 32'd1028, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data || cyc !== e.cycles) begin
      n_fail++; $display("FAIL wr_hit_reload: got %h in %0d cycles want %h in %0d", rd, cyc, e.data, e.cycles);
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int cyc; exp_t e;
    sram_lat = 2;
    push_exp(32'h0, 0, 3);
    run_req(0, 1, 32'd2048, 32'hCAFEF00D, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== e.cycles) begin n_fail++; $display("FAIL wr_miss_latency: got %0d want %0d", cyc, e.cycles); end
    n_checks++;
    if (m_cwr !== 0) begin n_fail++; $display("FAIL wr_miss_no_cache_write: got %0d writes want 0", m_cwr); end
    n_checks++;
    if (sram_mem[512] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wr_miss_sram_data: got %h want cafef00d", sram_mem[512]);
    end
    push_exp(ref_mem[512], 1, 3);
    run_req(1, 0, 32'd2048, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data || cyc !== e.cycles) begin
      n_fail++; $display("FAIL wr_miss_reload: got %h in %0d cycles want %h in %0d", rd, cyc, e.data, e.cycles);
    end
  endtask

  task automatic test_both_enables();
    logic [31:0] rd; int cyc; exp_t e;
    sram_lat = 2;
    push_exp(32'h0, 0, 3);
    run_req(1, 1, 32'd1024, 32'h55AA55AA, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== e.cycles) begin n_fail++; $display("FAIL both_latency: got %0d want %0d", cyc, e.cycles); end
    n_checks++;
    if (m_rcyc !== 0 || m_wcyc !== 2 || m_both !== 1'b0) begin
      n_fail++; $display("FAIL both_as_write: got r_en %0d w_en %0d overlap %b want 0,2,0", m_rcyc, m_wcyc, m_both);
    end
    n_checks++;
    if ({m_rdy_upd, m_rdy_wd2, m_rdy_wd1} !== {1'b1, 64'h12345678_55AA55AA}) begin
      n_fail++; $display("FAIL both_merge: got upd %b %h_%h want 1 12345678_55aa55aa", m_rdy_upd, m_rdy_wd2, m_rdy_wd1);
    end
  endtask

  task automatic test_spurious_ready();
    logic [31:0] rd; int cyc; exp_t e;
    spur = 1;
    @(negedge clk);
    n_checks++;
    if ({ready, sram_r_en, sram_w_en, cache_en_write} !== 4'b0) begin
      n_fail++; $display("FAIL idle_spurious_ready: got ready %b r %b w %b cw %b want 0",
                         ready, sram_r_en, sram_w_en, cache_en_write);
    end
    @(posedge clk); #1;
    spur = 0;
    push_exp(ref_mem[256], 1, 1);
    run_req(1, 0, 32'd1024, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data || cyc !== e.cycles) begin
      n_fail++; $display("FAIL post_spurious_hit: got %h in %0d cycles want %h in %0d", rd, cyc, e.data, e.cycles);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] rd; int cyc; int wr_snap; exp_t e;
    sram_lat = 8;
    MEM_R_EN = 1; MEM_W_EN = 0; address = 32'd1040; wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sram_r_en !== 1'b1) begin n_fail++; $display("FAIL mid_miss_pending: got r_en %b want 1", sram_r_en); end
    wr_snap = cache_wr_count;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({ready, rdata, cache_address, cache_en_read, cache_en_write, cache_update, cache_wdata1,
         cache_wdata2, sram_r_en, sram_w_en, sram_address, sram_wdata} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got ready %b r_en %b rdata %h caddr %h saddr %h want all 0",
                         ready, sram_r_en, rdata, cache_address, sram_address);
    end
    @(posedge clk); #1;
    rst = 0;
    n_checks++;
    if (cache_wr_count !== wr_snap) begin
      n_fail++; $display("FAIL mid_reset_no_fill: got %0d cache writes want %0d", cache_wr_count, wr_snap);
    end
    push_exp(ref_mem[260], 1, 9);
    run_req(1, 0, 32'd1040, 32'h0, rd, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (rd !== e.data || cyc !== e.cycles) begin
      n_fail++; $display("FAIL mid_reset_restart: got %h in %0d cycles want %h in %0d", rd, cyc, e.data, e.cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [4]; int cyc [4]; exp_t e;
    sram_lat = 1;
    push_exp(ref_mem[256], 1, 1);
    push_exp(ref_mem[262], 1, 2);
    push_exp(32'h0, 0, 2);
    push_exp(32'h77777777, 1, 1);
    run_req(1, 0, 32'd1024, 32'h0, rd[0], cyc[0]);
    run_req(1, 0, 32'd1048, 32'h0, rd[1], cyc[1]);
    run_req(0, 1, 32'd1024, 32'h77777777, rd[2], cyc[2]);
    run_req(1, 0, 32'd1024, 32'h0, rd[3], cyc[3]);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (cyc[i] !== e.cycles) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc[i], e.cycles);
      end
      if (e.chk_data) begin
        n_checks++;
        if (rd[i] !== e.data) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd[i], e.data); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[256] = 32'hAAAA0001;
    ref_mem[257] = 32'hBBBB0002;
    ref_mem[260] = 32'h0BADCAFE;
    ref_mem[261] = 32'h0000F00D;
    ref_mem[262] = 32'h600DF00D;
    rst = 1; MEM_R_EN = 0; MEM_W_EN = 0; address = 0; wdata = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_both_enables();
    test_spurious_ready();
    test_reset_mid_miss();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
